// File: rtl/eq_sweep_pkg.sv
// Shared types and helpers for the comparator sweep checker: FSM states,
// vector-count derivation and the golden equality model.
package eq_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    // Widest operand the golden model accepts; callers zero-extend into it.
    localparam int MAX_WIDTH = 8;

    function automatic int num_vec(input int width);
        return 1 << (2 * width);
    endfunction

    function automatic logic exp_eq(input logic [MAX_WIDTH-1:0] a,
                                    input logic [MAX_WIDTH-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/eq_sweep_checker_if.sv
// Handshake and operand/verdict bundle between the sweep checker, its
// controller and the comparator under test.
interface eq_sweep_checker_if #(
    parameter int WIDTH = 2
);
    logic               start;
    logic               f_in;
    logic [WIDTH-1:0]   a_out;
    logic [WIDTH-1:0]   b_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [2*WIDTH:0]   err_count;
    logic               fail_valid;
    logic [2*WIDTH-1:0] first_fail;

    modport master (
        output start,
        output f_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail
    );

    modport slave (
        input  start,
        input  f_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail
    );
endinterface

// File: rtl/eq_sweep_checker.sv
// Exhaustive sweep of every (A, B) operand pair into an equality comparator,
// checking its flag against the golden model and reporting a verdict.
module eq_sweep_checker
    import eq_sweep_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    eq_sweep_checker_if.slave bus
);

    localparam int VW      = 2 * WIDTH;
    localparam int CW      = 2 * WIDTH + 1;
    localparam int NUM_VEC = num_vec(WIDTH);

    localparam logic [VW-1:0] LAST_VEC    = VW'(NUM_VEC - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
    // With no settle time the FSM skips APPLY and samples every cycle.
    localparam state_t        RUN_STATE   = (SETTLE > 0) ? APPLY : SAMPLE;

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [3:0]      r_settle;
    logic [CW-1:0]   r_errCount;
    logic            r_failValid;
    logic [VW-1:0]   r_firstFail;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic [MAX_WIDTH-1:0] w_aExt;
    logic [MAX_WIDTH-1:0] w_bExt;
    logic                 w_mismatch;
    logic [CW-1:0]        w_errNext;

    assign w_aExt     = MAX_WIDTH'(r_vec[VW-1:WIDTH]);
    assign w_bExt     = MAX_WIDTH'(r_vec[WIDTH-1:0]);
    assign w_mismatch = (bus.f_in != exp_eq(w_aExt, w_bExt));
    assign w_errNext  = r_errCount + CW'(w_mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_settle    <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_firstFail <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state     <= RUN_STATE;
                        r_vec       <= '0;
                        r_settle    <= '0;
                        r_errCount  <= '0;
                        r_failValid <= 1'b0;
                        r_firstFail <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= SAMPLE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_errCount <= w_errNext;
                        if (!r_failValid) begin
                            r_firstFail <= r_vec;
                            r_failValid <= 1'b1;
                        end
                    end
                    // The verdict uses the count including this final sample.
                    if (r_vec == LAST_VEC) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_errNext == '0);
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_state <= RUN_STATE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a_out      = r_vec[VW-1:WIDTH];
    assign bus.b_out      = r_vec[WIDTH-1:0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_errCount;
    assign bus.fail_valid = r_failValid;
    assign bus.first_fail = r_firstFail;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Directed bench for eq_sweep_checker: two instances (SETTLE=1 and SETTLE=0)
// each driving a selectable model of the comparator under test.
module tb_eq_sweep_checker;

    localparam int MODE_IDEAL  = 0;
    localparam int MODE_STUCK0 = 1;
    localparam int MODE_STUCK1 = 2;
    localparam int MODE_INVERT = 3;
    localparam int MODE_REG    = 4;

    logic clock;
    logic reset;
    int   mode;
    int   tests;
    int   failures;
    logic regEq0;
    logic regEq1;

    eq_sweep_checker_if #(.WIDTH(2)) ifc1 ();
    eq_sweep_checker_if #(.WIDTH(2)) ifc0 ();

    eq_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk (clock),
        .rst (reset),
        .bus (ifc1.slave)
    );

    eq_sweep_checker #(.WIDTH(2), .SETTLE(0)) dut0 (
        .clk (clock),
        .rst (reset),
        .bus (ifc0.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Comparator-under-test models: ideal, stuck, inverted, or one-cycle registered.
    always @(posedge clock) begin
        regEq1 <= (ifc1.a_out == ifc1.b_out);
        regEq0 <= (ifc0.a_out == ifc0.b_out);
    end

    function automatic logic compModel(input int m, input logic [1:0] a,
                                       input logic [1:0] b, input logic r);
        case (m)
            MODE_STUCK0: return 1'b0;
            MODE_STUCK1: return 1'b1;
            MODE_INVERT: return (a != b);
            MODE_REG:    return r;
            default:     return (a == b);
        endcase
    endfunction

    assign ifc1.f_in = compModel(mode, ifc1.a_out, ifc1.b_out, regEq1);
    assign ifc0.f_in = compModel(mode, ifc0.a_out, ifc0.b_out, regEq0);

    function automatic logic [31:0] errOf(input int which);
        return (which == 0) ? 32'(ifc0.err_count) : 32'(ifc1.err_count);
    endfunction
    function automatic logic [31:0] firstOf(input int which);
        return (which == 0) ? 32'(ifc0.first_fail) : 32'(ifc1.first_fail);
    endfunction
    function automatic logic fvOf(input int which);
        return (which == 0) ? ifc0.fail_valid : ifc1.fail_valid;
    endfunction
    function automatic logic passOf(input int which);
        return (which == 0) ? ifc0.pass : ifc1.pass;
    endfunction
    function automatic logic doneOf(input int which);
        return (which == 0) ? ifc0.done : ifc1.done;
    endfunction
    function automatic logic busyOf(input int which);
        return (which == 0) ? ifc0.busy : ifc1.busy;
    endfunction
    function automatic logic [31:0] vecOf(input int which);
        return (which == 0) ? 32'({ifc0.a_out, ifc0.b_out})
                            : 32'({ifc1.a_out, ifc1.b_out});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setStart(input int which, input logic value);
        if (which == 0) ifc0.start = value;
        else            ifc1.start = value;
    endtask

    // Launch one run, check the launch edge, then wait (bounded) for done.
    task automatic applyStimulus(input int which, input int fmode,
                                 input bit holdStart, output int latency);
        mode = fmode;
        @(negedge clock);
        setStart(which, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("launchBusy", 32'(busyOf(which)), 1);
        checkOutput("launchDone", 32'(doneOf(which)), 0);
        checkOutput("launchVec", vecOf(which), 0);
        latency = 0;
        if (!holdStart) setStart(which, 1'b0);
        while (!doneOf(which) && latency < 200) begin
            @(posedge clock);
            #1;
            latency++;
        end
        checkOutput("doneReached", 32'(doneOf(which)), 1);
        checkOutput("busyAtDone", 32'(busyOf(which)), 0);
        @(negedge clock);
        setStart(which, 1'b0);
    endtask

    task automatic checkRun(input string tag, input int which, input int expErr,
                            input int expFv, input int expFirst, input int expPass);
        checkOutput({tag, ".err"},   errOf(which),          32'(expErr));
        checkOutput({tag, ".fv"},    32'(fvOf(which)),      32'(expFv));
        checkOutput({tag, ".first"}, firstOf(which),        32'(expFirst));
        checkOutput({tag, ".pass"},  32'(passOf(which)),    32'(expPass));
    endtask

    initial begin
        int lat;
        int guard;
        tests      = 0;
        failures   = 0;
        mode       = MODE_IDEAL;
        reset      = 1'b1;
        ifc1.start = 1'b0;
        ifc0.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        checkOutput("rst.busy", 32'(ifc1.busy), 0);
        checkOutput("rst.done", 32'(ifc1.done), 0);
        checkOutput("rst.vec",  vecOf(1), 0);
        checkRun("rst", 1, 0, 0, 0, 0);

        applyStimulus(1, MODE_IDEAL, 1'b0, lat);
        checkOutput("ideal.latency", 32'(lat), 32);
        checkRun("ideal", 1, 0, 0, 0, 1);
        checkOutput("ideal.holdVec", vecOf(1), 15);

        applyStimulus(1, MODE_STUCK0, 1'b0, lat);
        checkRun("stuck0", 1, 4, 1, 0, 0);

        applyStimulus(1, MODE_STUCK1, 1'b0, lat);
        checkRun("stuck1", 1, 12, 1, 1, 0);

        applyStimulus(1, MODE_INVERT, 1'b0, lat);
        checkRun("invert", 1, 16, 1, 0, 0);

        applyStimulus(1, MODE_REG, 1'b0, lat);
        checkRun("reg.s1", 1, 0, 0, 0, 1);

        applyStimulus(0, MODE_REG, 1'b0, lat);
        checkOutput("reg.s0.latency", 32'(lat), 16);
        checkRun("reg.s0", 0, 6, 1, 1, 0);

        applyStimulus(0, MODE_IDEAL, 1'b0, lat);
        checkRun("ideal.s0", 0, 0, 0, 0, 1);

        // start held high for the whole run must not restart before DONE
        applyStimulus(1, MODE_STUCK0, 1'b1, lat);
        checkOutput("hold.latency", 32'(lat), 32);
        checkRun("hold", 1, 4, 1, 0, 0);

        applyStimulus(1, MODE_IDEAL, 1'b0, lat);
        checkRun("restart", 1, 0, 0, 0, 1);

        // Mid-run reset while vector 7 is on the operands
        mode = MODE_STUCK1;
        @(negedge clock);
        ifc1.start = 1'b1;
        @(negedge clock);
        ifc1.start = 1'b0;
        guard = 0;
        while (vecOf(1) != 7 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("midrun.vec", vecOf(1), 7);
        checkOutput("midrun.busy", 32'(ifc1.busy), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midrst.busy", 32'(ifc1.busy), 0);
        checkOutput("midrst.done", 32'(ifc1.done), 0);
        checkOutput("midrst.vec",  vecOf(1), 0);
        checkRun("midrst", 1, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle.busy", 32'(ifc1.busy), 0);

        applyStimulus(1, MODE_IDEAL, 1'b0, lat);
        checkOutput("postrst.latency", 32'(lat), 32);
        checkRun("postrst", 1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
